// File: rtl/pipeline_skid_stage_pkg.sv
// rtl/pipeline_skid_stage_pkg.sv - shared types for the pipeline boundary stages
package pipeline_skid_stage_pkg;

  // Occupancy of a stage, encoded as {m_valid, s_valid}; 2'b01 is never entered.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b10,
    SKID_FULL  = 2'b11
  } skid_state_e;

  // Boundary labels, used to tag perf counters when several stages are collected.
  typedef enum logic [1:0] {
    STAGE_IF_ID  = 2'd0,
    STAGE_ID_EX  = 2'd1,
    STAGE_EX_MEM = 2'd2,
    STAGE_MEM_WB = 2'd3
  } pipe_stage_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] npc;
  } if_id_t;

  typedef struct packed {
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        halt;
    logic [3:0]  aluop;
    logic [31:0] rdat1;
    logic [31:0] rdat2;
    logic [31:0] imm;
    logic [31:0] npc;
    logic [4:0]  rd;
  } id_ex_t;

  typedef struct packed {
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        halt;
    logic [31:0] aluoutput;
    logic [31:0] storedata;
    logic [4:0]  rd;
  } ex_mem_t;

  typedef struct packed {
    logic        regwrite;
    logic        halt;
    logic        memtoreg;
    logic [31:0] dmemload;
    logic [31:0] aluoutput;
    logic [4:0]  rd;
  } mem_wb_t;

  // Payload widths handed to WIDTH when each boundary is instantiated.
  localparam int IF_ID_W  = $bits(if_id_t);
  localparam int ID_EX_W  = $bits(id_ex_t);
  localparam int EX_MEM_W = $bits(ex_mem_t);
  localparam int MEM_WB_W = $bits(mem_wb_t);

endpackage

// File: rtl/pipeline_skid_stage_if.sv
// rtl/pipeline_skid_stage_if.sv - valid/ready handshake bundle around one stage
interface pipeline_skid_stage_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // Environment side: drives the upstream payload and the downstream ready.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Stage side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipeline_skid_stage_pipe_sat_counter.sv
// rtl/pipeline_skid_stage_pipe_sat_counter.sv - saturating event counter with sync clear
module pipe_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  // Clear wins over an increment in the same cycle; the count sticks at all-ones.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_skid_stage.sv
// rtl/pipeline_skid_stage.sv - elastic 2-entry skid stage; PIPE_STAGE_PERF_EN adds stall/bubble counters
module pipeline_skid_stage
  import pipeline_skid_stage_pkg::*;
#(
  parameter int               WIDTH         = 32,
  parameter logic [WIDTH-1:0] RESET_PAYLOAD = '0,
  parameter int               CNT_W         = 32
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 flush,
  pipeline_skid_stage_if.slave bus
`ifdef PIPE_STAGE_PERF_EN
  ,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt
`endif
);

  if (WIDTH < 1 || CNT_W < 1) begin : g_bad_param
    $error("pipeline_skid_stage: WIDTH and CNT_W must be at least 1");
  end

  skid_state_e      state;
  logic [WIDTH-1:0] m_data;
  logic [WIDTH-1:0] s_data;
  logic             in_ready_q;
  logic             m_valid;
  logic             accept;
  logic             drain;

  // Occupancy bits come straight out of the state encoding.
  assign m_valid = state[1];
  assign accept  = bus.in_valid && in_ready_q;
  assign drain   = m_valid && bus.out_ready;

  // Stage FSM; in_ready is computed alongside the state so it is a flop, not a ready chain.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= SKID_EMPTY;
      m_data     <= RESET_PAYLOAD;
      s_data     <= RESET_PAYLOAD;
      in_ready_q <= 1'b1;
    end else if (flush) begin
      state      <= SKID_EMPTY;
      m_data     <= RESET_PAYLOAD;
      s_data     <= RESET_PAYLOAD;
      in_ready_q <= 1'b1;
    end else begin
      case (state)
        SKID_EMPTY: begin
          if (accept) begin
            m_data <= bus.in_data;
            state  <= SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (accept && drain) begin
            m_data <= bus.in_data;
          end else if (accept) begin
            s_data     <= bus.in_data;
            state      <= SKID_FULL;
            in_ready_q <= 1'b0;
          end else if (drain) begin
            state <= SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          // in_ready is low here, so only the drain side can move.
          if (drain) begin
            m_data     <= s_data;
            state      <= SKID_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state      <= SKID_EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = m_valid;
  assign bus.out_data  = m_data;

`ifdef PIPE_STAGE_PERF_EN
  logic stall_inc;
  logic bubble_inc;

  assign stall_inc  = m_valid && !bus.out_ready;
  assign bubble_inc = !m_valid;

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (stall_inc),
    .clr  (cnt_clr),
    .cnt  (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (bubble_inc),
    .clr  (cnt_clr),
    .cnt  (bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_pipeline_skid_stage.sv
// tb/tb_pipeline_skid_stage.sv - self-checking bench; counter checks run when PIPE_STAGE_PERF_EN is defined
module tb_pipeline_skid_stage;

  localparam int         W  = 8;
  localparam logic [7:0] RP = 8'h5A;
  localparam int         CW = 4;

  logic CLK = 1'b0;
  logic nRST;
  logic flush;

  pipeline_skid_stage_if #(.WIDTH(W)) bus ();

`ifdef PIPE_STAGE_PERF_EN
  logic          cnt_clr;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] bubble_cnt;
`endif

  pipeline_skid_stage #(
    .WIDTH         (W),
    .RESET_PAYLOAD (RP),
    .CNT_W         (CW)
  ) dut (
    .CLK   (CLK),
    .nRST  (nRST),
    .flush (flush),
    .bus   (bus.slave)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .cnt_clr    (cnt_clr),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      passed++;
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       fl;
    logic       eov;
    logic [7:0] eod;
    logic       eir;
  } vec_t;

  vec_t vecs[13];

  // Reference: the stage behaves as a FIFO of depth 2 whose ready means "fewer than 2 held".
  logic [7:0] q[$];

  task automatic drive(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    flush         = fl;
  endtask

  initial begin
    // cycle-by-cycle directed table: stream, fill/drain, flush with pending input
    vecs[0]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1};
    vecs[1]  = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1};
    vecs[2]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 8'h33, 1'b1};
    vecs[3]  = '{1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h33, 1'b1};
    vecs[4]  = '{1'b1, 8'h0A, 1'b0, 1'b0, 1'b1, 8'h0A, 1'b1};
    vecs[5]  = '{1'b1, 8'h0B, 1'b0, 1'b0, 1'b1, 8'h0A, 1'b0};
    vecs[6]  = '{1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, 8'h0A, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h0B, 1'b1};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h0B, 1'b1};
    vecs[9]  = '{1'b1, 8'h0C, 1'b0, 1'b0, 1'b1, 8'h0C, 1'b1};
    vecs[10] = '{1'b1, 8'h0D, 1'b0, 1'b0, 1'b1, 8'h0C, 1'b0};
    vecs[11] = '{1'b1, 8'h0E, 1'b0, 1'b1, 1'b0, RP,    1'b1};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, RP,    1'b1};

    nRST = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
`ifdef PIPE_STAGE_PERF_EN
    cnt_clr = 1'b0;
`endif
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_in_ready",  32'(bus.in_ready),  32'd1);
    chk("reset_out_data",  32'(bus.out_data),  32'(RP));
    @(negedge CLK);
    nRST = 1'b1;

    for (int i = 0; i < 13; i++) begin
      @(negedge CLK);
      drive(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
      @(posedge CLK);
      #1;
      chk($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].eov));
      chk($sformatf("vec%0d_out_data", i),  32'(bus.out_data),  32'(vecs[i].eod));
      chk($sformatf("vec%0d_in_ready", i),  32'(bus.in_ready),  32'(vecs[i].eir));
    end

    // fill to FULL, then reset asynchronously between edges
    @(negedge CLK);
    drive(1'b1, 8'h21, 1'b0, 1'b0);
    @(negedge CLK);
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    @(posedge CLK);
    #1;
    chk("prereset_full_in_ready", 32'(bus.in_ready), 32'd0);
    #2;
    nRST = 1'b0;
    #1;
    chk("async_reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("async_reset_in_ready",  32'(bus.in_ready),  32'd1);
    chk("async_reset_out_data",  32'(bus.out_data),  32'(RP));
    @(negedge CLK);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    nRST = 1'b1;

    // randomized traffic against the FIFO reference
    q.delete();
    for (int c = 0; c < 1000; c++) begin
      logic       iv, ordy, fl, m_rdy;
      logic [7:0] d;
      @(negedge CLK);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 49) == 0);
      d    = 8'($urandom);
      drive(iv, d, ordy, fl);
      m_rdy = (q.size() < 2);
      if (fl) begin
        q.delete();
      end else begin
        if (q.size() > 0 && ordy) void'(q.pop_front());
        if (iv && m_rdy) q.push_back(d);
      end
      @(posedge CLK);
      #1;
      chk("rand_out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
      chk("rand_in_ready",  32'(bus.in_ready),  32'(q.size() < 2));
      if (q.size() > 0) chk("rand_out_data", 32'(bus.out_data), 32'(q[0]));
      if (!bus.out_valid) chk("rand_no_skid_without_main", 32'(bus.in_ready), 32'd1);
    end

`ifdef PIPE_STAGE_PERF_EN
    @(negedge CLK);
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    @(negedge CLK);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    cnt_clr = 1'b1;
    @(posedge CLK);
    #1;
    chk("clr_with_bubble_stall",  32'(stall_cnt),  32'd0);
    chk("clr_with_bubble_bubble", 32'(bubble_cnt), 32'd0);
    @(negedge CLK);
    cnt_clr = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("idle3_bubble", 32'(bubble_cnt), 32'd3);
    chk("idle3_stall",  32'(stall_cnt),  32'd0);
    @(negedge CLK);
    drive(1'b1, 8'h77, 1'b0, 1'b0);
    @(negedge CLK);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (19) @(posedge CLK);
    @(negedge CLK);
    chk("stall20_sat", 32'(stall_cnt),  32'd15);
    chk("stall20_bubble", 32'(bubble_cnt), 32'd4);
    cnt_clr = 1'b1;
    @(posedge CLK);
    #1;
    chk("clr_stall",  32'(stall_cnt),  32'd0);
    chk("clr_bubble", 32'(bubble_cnt), 32'd0);
    @(negedge CLK);
    cnt_clr = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
